// File: rtl/xor_parity_sched.sv
// xor_parity_sched: round-robin scheduler sharing one bit-serial XOR (parity)
// engine among NREQ requesters.
//   clk, rst_n      : rising-edge clock, asynchronous active-low reset
//   req[NREQ]       : per-requester request, held until done or abort
//   data[NREQ*W]    : flattened request words, requester i at [i*W +: W]
//   gnt[NREQ]       : one-hot grant, high while requester is served
//   busy            : high whenever the engine is not idle
//   done            : one-cycle completion pulse
//   done_id[IDW]    : ID of the last completed requester (held)
//   parity          : XOR of all bits of the last completed word (held)
`timescale 1ns/1ps

module xor_parity_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] data,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              done,
    output logic [IDW-1:0]    done_id,
    output logic              parity
);

    localparam int unsigned CNTW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    logic [NREQ-1:0]   r_gnt;
    logic [IDW-1:0]    r_id;
    logic [W-1:0]      r_sreg;
    logic              r_acc;
    logic [CNTW-1:0]   r_cnt;
    logic [IDW-1:0]    r_rr_ptr;
    logic              r_parity;
    logic [IDW-1:0]    r_done_id;
    logic              r_busy;
    logic              r_done;

    state_t            w_state_nxt;
    logic [NREQ-1:0]   w_gnt_nxt;
    logic [IDW-1:0]    w_id_nxt;
    logic [W-1:0]      w_sreg_nxt;
    logic              w_acc_nxt;
    logic [CNTW-1:0]   w_cnt_nxt;
    logic [IDW-1:0]    w_rr_nxt;
    logic              w_parity_nxt;
    logic [IDW-1:0]    w_done_id_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;

    logic              w_pick_vld;
    logic [IDW-1:0]    w_pick_id;
    logic [W-1:0]      w_pick_word;
    logic              w_held;
    logic [IDW-1:0]    w_rr_inc;

    // Round-robin pick: first set req at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        int unsigned v_idx;
        v_idx       = 0;
        w_pick_vld  = 1'b0;
        w_pick_id   = '0;
        w_pick_word = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            v_idx = (32'(r_rr_ptr) + k) % NREQ;
            if (!w_pick_vld && req[v_idx]) begin
                w_pick_vld  = 1'b1;
                w_pick_id   = IDW'(v_idx);
                w_pick_word = data[v_idx*W +: W];
            end
        end
    end

    // Granted requester still holding its request (low means abort).
    assign w_held   = |(req & r_gnt);
    assign w_rr_inc = (r_id == IDW'(NREQ - 1)) ? '0 : IDW'(r_id + 1'b1);

    // Next-state and datapath control.
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_id_nxt      = r_id;
        w_sreg_nxt    = r_sreg;
        w_acc_nxt     = r_acc;
        w_cnt_nxt     = r_cnt;
        w_rr_nxt      = r_rr_ptr;
        w_parity_nxt  = r_parity;
        w_done_id_nxt = r_done_id;

        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = ST_SHIFT;
                    w_gnt_nxt   = NREQ'(1) << w_pick_id;
                    w_id_nxt    = w_pick_id;
                    w_sreg_nxt  = w_pick_word;
                    w_acc_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SHIFT: begin
                if (!w_held) begin
                    // Abort: drop grant, keep previous result, move pointer past us.
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                    w_rr_nxt    = w_rr_inc;
                end else begin
                    w_acc_nxt  = r_acc ^ r_sreg[0];
                    w_sreg_nxt = r_sreg >> 1;
                    w_cnt_nxt  = CNTW'(r_cnt + 1'b1);
                    if (r_cnt == CNTW'(W - 1)) begin
                        w_state_nxt   = ST_DONE;
                        w_parity_nxt  = r_acc ^ r_sreg[0];
                        w_done_id_nxt = r_id;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_rr_nxt    = w_rr_inc;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_id      <= '0;
            r_sreg    <= '0;
            r_acc     <= 1'b0;
            r_cnt     <= '0;
            r_rr_ptr  <= '0;
            r_parity  <= 1'b0;
            r_done_id <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_id      <= w_id_nxt;
            r_sreg    <= w_sreg_nxt;
            r_acc     <= w_acc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rr_ptr  <= w_rr_nxt;
            r_parity  <= w_parity_nxt;
            r_done_id <= w_done_id_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign busy    = r_busy;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign parity  = r_parity;

endmodule

// File: tb/tb_xor_parity_sched.sv
// tb_xor_parity_sched: directed self-checking bench for xor_parity_sched
// (NREQ=4, W=8, IDW=2).
`timescale 1ns/1ps

module tb_xor_parity_sched;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 8;
    localparam int unsigned IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] data;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              done;
    logic [IDW-1:0]    done_id;
    logic              parity;

    int errors = 0;
    int checks = 0;

    xor_parity_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .data    (data),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .parity  (parity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; drive and sample 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after E0. Counts edges including E0 until done is seen.
    task automatic wait_done(output int edges, output logic seen);
        edges = 1;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            edges++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic set_word(input int idx, input logic [W-1:0] w);
        data[idx*W +: W] = w;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '0;
        data  = '0;
        #12;
        checks++;
        if ({gnt, busy, done, done_id, parity} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b busy=%b done=%b id=%0d par=%b want all 0",
                     gnt, busy, done, done_id, parity);
        end
        rst_n = 1'b1;
        tick();
    endtask

    // One complete job for requester id; expects given parity and grant.
    task automatic run_job(input string nm, input int id, input logic exp_par);
        int   edges;
        logic seen;
        tick();
        checks++;
        if (gnt !== 4'(1 << id) || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_gnt: got gnt=%b busy=%b want gnt=%b busy=1", nm, gnt, busy, 4'(1 << id));
        end
        wait_done(edges, seen);
        checks++;
        if (!seen || edges != W + 1) begin
            errors++;
            $display("FAIL %s_latency: got seen=%b edges=%0d want edges=%0d", nm, seen, edges, W + 1);
        end
        checks++;
        if (done_id !== IDW'(id) || parity !== exp_par || gnt !== 4'(1 << id)) begin
            errors++;
            $display("FAIL %s_result: got id=%0d par=%b gnt=%b want id=%0d par=%b gnt=%b",
                     nm, done_id, parity, gnt, id, exp_par, 4'(1 << id));
        end
        req[id] = 1'b0;
        tick();
        checks++;
        if (done !== 1'b0 || gnt !== '0 || busy !== 1'b0 || done_id !== IDW'(id) || parity !== exp_par) begin
            errors++;
            $display("FAIL %s_after: got done=%b gnt=%b busy=%b id=%0d par=%b want 0 0000 0 %0d %b",
                     nm, done, gnt, busy, done_id, parity, id, exp_par);
        end
    endtask

    task automatic test_single_parity0();
        set_word(0, 8'hA5);
        req = 4'b0001;
        run_job("single_p0", 0, 1'b0);
    endtask

    task automatic test_single_parity1();
        set_word(1, 8'h07);
        req = 4'b0010;
        run_job("single_p1", 1, 1'b1);
        set_word(1, 8'h00);
        req = 4'b0010;
        run_job("single_p1_zero", 1, 1'b0);
    endtask

    task automatic test_round_robin();
        int   edges;
        logic seen;
        logic [W-1:0] words [NREQ] = '{8'h01, 8'h03, 8'h07, 8'h0F};
        logic         pars  [NREQ] = '{1'b1, 1'b0, 1'b1, 1'b0};
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < NREQ; i++) set_word(i, words[i]);
        req = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            tick();
            checks++;
            if (gnt !== 4'(1 << (j % NREQ))) begin
                errors++;
                $display("FAIL rr_gnt_%0d: got %b want %b", j, gnt, 4'(1 << (j % NREQ)));
            end
            wait_done(edges, seen);
            checks++;
            if (!seen || done_id !== IDW'(j % NREQ) || parity !== pars[j % NREQ]) begin
                errors++;
                $display("FAIL rr_done_%0d: got seen=%b id=%0d par=%b want id=%0d par=%b",
                         j, seen, done_id, parity, j % NREQ, pars[j % NREQ]);
            end
            req[j % NREQ] = 1'b0;
            tick();
            req = 4'b1111;
        end
        req = '0;
        tick();
    endtask

    task automatic test_abort();
        logic saw_done = 1'b0;
        set_word(2, 8'hFF);
        set_word(3, 8'h80);
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL abort_gnt: got %b want 0100", gnt);
        end
        req = 4'b1100;
        for (int i = 0; i < 3; i++) begin
            tick();
            saw_done |= done;
        end
        req = 4'b1000;
        tick();
        saw_done |= done;
        checks++;
        if (gnt !== '0 || busy !== 1'b0 || saw_done !== 1'b0 || done_id !== 2'd3 || parity !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: got gnt=%b busy=%b done_seen=%b id=%0d par=%b want 0000 0 0 3 0",
                     gnt, busy, saw_done, done_id, parity);
        end
        run_job("abort_next", 3, 1'b1);
    endtask

    task automatic test_async_reset();
        set_word(2, 8'h01);
        req = 4'b0100;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, busy, done, done_id, parity} !== '0) begin
            errors++;
            $display("FAIL async_reset: got gnt=%b busy=%b done=%b id=%0d par=%b want all 0",
                     gnt, busy, done, done_id, parity);
        end
        req = 4'b1001;
        set_word(0, 8'h03);
        set_word(3, 8'h01);
        tick();
        rst_n = 1'b1;
        run_job("post_reset", 0, 1'b0);
        req = '0;
        tick();
    endtask

    task automatic test_data_stability();
        int   edges;
        logic seen;
        set_word(0, 8'h01);
        req = 4'b0001;
        tick();
        set_word(0, 8'h03);
        wait_done(edges, seen);
        checks++;
        if (!seen || parity !== 1'b1 || done_id !== 2'd0) begin
            errors++;
            $display("FAIL data_stable: got seen=%b par=%b id=%0d want par=1 id=0", seen, parity, done_id);
        end
        req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_parity0();
        test_single_parity1();
        test_round_robin();
        test_abort();
        test_async_reset();
        test_data_stability();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xor_parity_sched.md
Name: xor_parity_sched

Overview:
- Round-robin scheduler that shares one bit-serial XOR (parity) engine among NREQ requesters.
- Grants one requester at a time and captures its W-bit word. It then sequences the 1-bit XOR accumulate over W cycles and returns the word's parity with the requester ID.
- Sits between request sources and the shared XOR datapath. Serialises access so a single XOR gate serves all clients.

Parameters:
- NREQ, 4, number of requesters (2..16).
- W, 8, data word width (>=2).
- IDW, 2, width of requester ID; NREQ <= 2**IDW.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester request; held high until done or abort.
- data  input  NREQ*W  flattened words; requester i uses bits [i*W+W-1 : i*W].
- gnt  output  NREQ  one-hot grant; high while requester is being served.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; parity/done_id valid.
- done_id  output  IDW  ID of the completed requester; holds until next done.
- parity  output  1  XOR of all W bits of the served word; holds until next done.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt=0, busy=0, done=0, done_id=0, parity=0, rr_ptr=0, shift/acc/count cleared. Takes effect immediately, mid-operation included. No done is produced for an interrupted job.
- States: IDLE, SHIFT, DONE.
- IDLE, no req bit set: stay in IDLE, outputs static.
- IDLE, any req bit set (sampling edge E0):
  - Select the first set req at or after rr_ptr, wrapping modulo NREQ.
  - Set gnt to its one-hot bit and store its ID.
  - Load its data word into the shift register; acc=0, cnt=0. Go to SHIFT.
- SHIFT, each edge:
  - acc <= acc ^ sreg[0]; sreg <= sreg >> 1; cnt <= cnt+1.
  - On the edge where cnt==W-1: go to DONE, parity <= final acc, done_id <= ID.
- DONE:
  - done=1 for exactly this one cycle; gnt still asserted.
  - Next edge: gnt=0, rr_ptr=(ID+1) mod NREQ, go to IDLE.
- Latency: done is high in the cycle beginning W+1 edges after E0. Throughput is one job per W+2 cycles; the mandatory IDLE cycle separates jobs.
- Data is captured only at E0. Changes on data after the grant are ignored.
- Requester rules:
  - Must deassert req on the edge ending its done cycle.
  - req still high in the following IDLE cycle is treated as a new request, subject to round-robin order.
- Abort:
  - If the granted requester's req is low at any SHIFT edge, next state is IDLE with gnt=0.
  - No done is produced; parity/done_id keep their previous values; rr_ptr=(ID+1) mod NREQ.
  - req dropping during the DONE cycle does not cancel done.
- Non-granted req changes during SHIFT/DONE have no effect until IDLE.
- Simultaneous requests: strictly round-robin from rr_ptr. No requester waits more than NREQ-1 jobs.
- gnt is never multi-hot. gnt=0 whenever state=IDLE.
- Unused done_id upper bits (when NREQ < 2**IDW) are 0.

Test Plan:
- Single job, parity 0: reset, req=0001, data0=0xA5 -> gnt=0001 after E0; done pulses 9 edges after E0; parity=0, done_id=0; busy low 1 cycle after done.
- Single job, parity 1: req=0010, data1=0x07 -> done_id=1, parity=1. Then data1=0x00 (new req) -> parity=0.
- Round-robin fairness: from reset, req=1111 held (each dropped on its done, re-raised the next cycle) -> grant order 0,1,2,3,0,1…; no two consecutive grants to the same ID while others pend.
- Abort: req=0100, data2=0xFF, drop req2 after the 3rd SHIFT edge -> gnt=0 next edge, no done, parity/done_id unchanged. With req3 pending, next grant=1000.
- Async reset mid-SHIFT: assert rst_n=0 between edges during SHIFT -> all outputs 0 immediately, without a clock. After release, with req=1001 -> grant goes to ID 0 first (rr_ptr=0).
- Data stability: grant req0 with data0=0x01, change data0 to 0x03 on the next cycle -> parity=1 (captured value used).
